matrix_stream_loader: RTL and testbench
=======================================

# matrix_stream_loader

Upstream feeder and result holder for the combinational 2x2 matrix multiplier. Accepts a serial stream of 16-bit elements under a valid/ready handshake and assembles operand matrices A and B into the multiplier's two 64-bit operand buses. One cycle after the operands are complete, it captures the multiplier's 64-bit product into a register. It presents that result downstream under a second valid/ready handshake, and can load the next operand pair while the previous result waits.

## Interface
- `ELEM_W`, default 16: element width. Matrix bus width is `4*ELEM_W`.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `in_valid` input, 1 bit: upstream element valid.
- `in_ready` output, 1 bit: block accepts `in_data` this cycle.
- `in_data` input, `ELEM_W` bits: element; order is A00, A01, A10, A11, B00, B01, B10, B11.
- `mm_a` output, 64 bits: operand A to the multiplier (`i0`).
- `mm_b` output, 64 bits: operand B to the multiplier (`i1`).
- `mm_o` input, 64 bits: product from the multiplier (`o`).
- `out_valid` output, 1 bit: `out_data` holds a result.
- `out_ready` input, 1 bit: downstream takes the result.
- `out_data` output, 64 bits: registered product.

## Operation
- **Packing:** element (r,c) occupies bits `[16*(2r+c)+15 : 16*(2r+c)]`, so A00 sits at bits [15:0].
- **Element counter `idx`** (3 bits, 0..7):
  - A handshake is `in_valid & in_ready`.
  - Each handshake writes slot `idx` and increments `idx`.
  - Slots 0..3 go to `mm_a`; slots 4..7 go to `mm_b`.
  - `idx` wraps 7→0.
- **Operand stability:** `mm_a` and `mm_b` change only on a handshake.
- **States:** LOAD, COMPUTE, OUTPUT.
- **LOAD:**
  - `in_ready` = 1.
  - A handshake at `idx`=7 moves to COMPUTE.
- **COMPUTE** (always exactly 1 cycle):
  - `in_ready` = 0.
  - `out_data <= mm_o`.
  - Next state is OUTPUT.
- **OUTPUT:**
  - `out_valid` = 1.
  - `in_ready` = 1 when `idx`≠7; when `idx`=7, `in_ready` = `out_ready`.
  - Handshake at `idx`=7 together with `out_ready` → COMPUTE (back-to-back pair).
  - `out_ready` without a final element → LOAD.
  - No `out_ready` → stay in OUTPUT; `out_data` is held.
- **Overlap:** elements accepted in OUTPUT overwrite operand slots. This is safe because `out_data` is registered.
- **No arithmetic in this block:** the multiplier's product, including its own truncation, passes through unmodified.

## Timing
- **Reset values:**
  - state LOAD, `idx`=0.
  - `mm_a`, `mm_b`, `out_data` = 0.
  - `out_valid` = 0, `in_ready` = 1 (the cycle after reset is released).
- **Reset mid-operation:** a partial operand set is discarded and a pending result is dropped.
- **Latency:** last element (B11) accepted at edge t → COMPUTE during cycle t..t+1 → `out_valid` first high after edge t+1.
- **Minimum spacing:** with continuous input and `out_ready` tied high, one result every 9 cycles (8 loads + 1 COMPUTE).
- **Handshake rules:**
  - `out_valid` never drops without `out_ready`.
  - `out_data` is stable while `out_valid & ~out_ready`.
  - `in_ready` is a function of state, `idx` and `out_ready` only, never of `in_valid`.
- **Stall:** when the final element arrives in OUTPUT while `out_ready` = 0, the element is not accepted and `idx` stays 7.
- **Combinational path:** the multiplier settles within the COMPUTE cycle, because `mm_a`/`mm_b` are frozen there.

## Structure
- A shared package `matrix_pkg` holds:
  - `ELEM_W`, `MAT_DIM`=2, `MAT_W`=64.
  - The state enum (LOAD/COMPUTE/OUTPUT).
  - A slot-offset function `slot_lo(r,c)`.
  - The multiplier reuses these constants.
- Sub-module `matrix_slot_reg`: a 64-bit register with a 2-bit slot write-enable. It is instantiated twice, once for A and once for B.
- The `matrixMultiplier` instance sits beside this block at the top level, not inside it.

## Test plan
- **Identity:** reset, then stream A=1,0,0,1 and B=1,2,3,4 with `out_ready`=1 → `out_data`=64'h0004_0003_0002_0001, with `out_valid` one cycle after the COMPUTE cycle.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after a result → `out_data` is stable and `out_valid` stays 1. Stream 7 elements of the next pair; the 8th sees `in_ready`=0. Raise `out_ready` → the 8th element is accepted that cycle and the next result follows.
- **Input gaps:** `in_valid` toggles randomly → slots fill only on handshakes, and the result matches the A=2,0,0,2, B=1,1,1,1 product 64'h0002_0002_0002_0002.
- **Reset mid-load:** assert `reset` after 5 elements → `idx`=0, `mm_a`=`mm_b`=0, `out_valid`=0. A fresh 8-element pair yields the correct result.
- **Back-to-back:** continuous input with `out_ready`=1 across 3 pairs → 3 results, 9 cycles apart, each equal to `mm_o` as sampled in its COMPUTE cycle.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants, FSM state type and element slot addressing for the 2x2 matrix datapath.
package matrix_pkg;

  localparam int unsigned ELEM_W  = 16;
  localparam int unsigned MAT_DIM = 2;
  localparam int unsigned MAT_W   = MAT_DIM * MAT_DIM * ELEM_W;

  typedef enum logic [1:0] {
    StLoad,
    StCompute,
    StOutput
  } state_e;

  // Row-major packing: element (r,c) starts at bit elem_w*(MAT_DIM*r+c).
  function automatic int unsigned slot_lo(input int unsigned r, input int unsigned c,
                                          input int unsigned elem_w = ELEM_W);
    return elem_w * (MAT_DIM * r + c);
  endfunction

endpackage

// File: rtl/matrix_slot_reg.sv
// One packed 2x2 operand register; a write loads a single element into the addressed slot.
module matrix_slot_reg #(
  parameter int unsigned ElemW = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [1:0]         slot,
  input  logic [ElemW-1:0]   wdata,
  output logic [4*ElemW-1:0] q
);
  import matrix_pkg::*;

  logic [4*ElemW-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (we) begin
      for (int unsigned r = 0; r < MAT_DIM; r++) begin
        for (int unsigned c = 0; c < MAT_DIM; c++) begin
          if (slot == 2'(MAT_DIM * r + c)) begin
            r_q[slot_lo(r, c, ElemW) +: ElemW] <= wdata;
          end
        end
      end
    end
  end

  assign q = r_q;

endmodule

// File: rtl/matrix_stream_loader.sv
// Streams eight elements into the A/B operand buses of the external 2x2 multiplier and
// holds its product for a downstream valid/ready consumer.
module matrix_stream_loader #(
  parameter int unsigned ELEM_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ELEM_W-1:0]   in_data,
  output logic [4*ELEM_W-1:0] mm_a,
  output logic [4*ELEM_W-1:0] mm_b,
  input  logic [4*ELEM_W-1:0] mm_o,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*ELEM_W-1:0] out_data
);
  import matrix_pkg::*;

  state_e              r_state;
  state_e              w_state_next;
  logic [2:0]          r_idx;
  logic [4*ELEM_W-1:0] r_out_data;
  logic                w_hs;
  logic                w_last_hs;

  assign w_hs      = in_valid & in_ready;
  assign w_last_hs = w_hs & (r_idx == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StLoad;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StLoad:    if (w_last_hs) w_state_next = StCompute;
      StCompute: w_state_next = StOutput;
      // A final element can only be taken here with out_ready high, so the result is consumed.
      StOutput: begin
        if (w_last_hs) begin
          w_state_next = StCompute;
        end else if (out_ready) begin
          w_state_next = StLoad;
        end
      end
      default:   w_state_next = StLoad;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      StLoad:    in_ready = 1'b1;
      StCompute: in_ready = 1'b0;
      StOutput: begin
        out_valid = 1'b1;
        in_ready  = (r_idx != 3'd7) | out_ready;
      end
      default:   in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= '0;
    end else if (w_hs) begin
      r_idx <= r_idx + 3'd1;
    end
  end

  // Operands are frozen during COMPUTE, so mm_o has settled by the capturing edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data <= '0;
    end else if (r_state == StCompute) begin
      r_out_data <= mm_o;
    end
  end

  assign out_data = r_out_data;

  matrix_slot_reg #(
    .ElemW (ELEM_W)
  ) u_slot_a (
    .clk   (clk),
    .reset (reset),
    .we    (w_hs & ~r_idx[2]),
    .slot  (r_idx[1:0]),
    .wdata (in_data),
    .q     (mm_a)
  );

  matrix_slot_reg #(
    .ElemW (ELEM_W)
  ) u_slot_b (
    .clk   (clk),
    .reset (reset),
    .we    (w_hs & r_idx[2]),
    .slot  (r_idx[1:0]),
    .wdata (in_data),
    .q     (mm_b)
  );

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed/randomized bench for matrix_stream_loader with a behavioural 2x2 multiplier and
// a scoreboard of expected products built from the accepted element stream.
module tb_matrix_stream_loader;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        in_valid  = 1'b0;
  logic [15:0] in_data   = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] mm_a;
  logic [63:0] mm_b;
  logic [63:0] mm_o;
  logic [63:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_stream_loader #(
    .ELEM_W (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_o      (mm_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // 2x2 product with 16-bit wrap per element; element (r,c) at bits 16*(2r+c).
  function automatic logic [63:0] matmul(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] p;
    logic [15:0] s;
    logic [15:0] ea;
    logic [15:0] eb;
    p = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        s = '0;
        for (int k = 0; k < 2; k++) begin
          ea = a[16*(2*r+k) +: 16];
          eb = b[16*(2*k+c) +: 16];
          s  = s + 16'(ea * eb);
        end
        p[16*(2*r+c) +: 16] = s;
      end
    end
    return p;
  endfunction

  assign mm_o = matmul(mm_a, mm_b);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard state
  logic [127:0] acc_vec = '0;
  logic [127:0] last_pair = '0;
  int           acc = 0;
  int           lat = 0;
  int           cyc = 0;
  logic         hold_valid = 1'b0;
  logic [63:0]  hold_data = '0;
  logic [63:0]  exp_q[$];
  logic [63:0]  mmo_q[$];
  int           pop_cyc[$];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        acc = 0;
        lat = 0;
        hold_valid = 1'b0;
        exp_q.delete();
        mmo_q.delete();
      end else begin
        if (lat == 1) begin
          chk("compute_out_valid", 64'(out_valid), 64'd0);
          chk("compute_in_ready", 64'(in_ready), 64'd0);
          chk("compute_mm_a", mm_a, last_pair[63:0]);
          chk("compute_mm_b", mm_b, last_pair[127:64]);
          mmo_q.push_back(mm_o);
          lat = 2;
        end else if (lat == 2) begin
          chk("latency_out_valid", 64'(out_valid), 64'd1);
          lat = 0;
        end
        if (hold_valid) begin
          chk("hold_out_valid", 64'(out_valid), 64'd1);
          chk("hold_out_data", out_data, hold_data);
        end
        hold_valid = out_valid && !out_ready;
        hold_data  = out_data;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0 || mmo_q.size() == 0) begin
            chk("unexpected_result", 64'(out_valid), 64'd0);
          end else begin
            chk("result_model", out_data, exp_q.pop_front());
            chk("result_mm_o", out_data, mmo_q.pop_front());
          end
          pop_cyc.push_back(cyc);
        end
        if (in_valid && in_ready) begin
          acc_vec[16*acc +: 16] = in_data;
          acc++;
          if (acc == 8) begin
            last_pair = acc_vec;
            exp_q.push_back(matmul(acc_vec[63:0], acc_vec[127:64]));
            acc = 0;
            lat = 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    logic rdy;
    int   n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      #1 rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 60) begin
        chk("send_timeout", 64'(rdy), 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [127:0] p, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      while (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        tick();
      end
      send(p[16*i +: 16]);
    end
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("out_valid_wait", 64'(out_valid), 64'd1);
  endtask

  function automatic logic [127:0] rand_pair();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [127:0] p;
    logic [127:0] p2;
    int           n0;
    int           n;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_mm_a", mm_a, 64'd0);
    chk("rst_mm_b", mm_b, 64'd0);

    // Identity
    out_ready = 1'b1;
    send_pair({16'd4, 16'd3, 16'd2, 16'd1, 16'd1, 16'd0, 16'd0, 16'd1}, 1'b0);
    wait_out();
    chk("identity", out_data, 64'h0004_0003_0002_0001);
    tick();

    // Backpressure
    out_ready = 1'b0;
    p = rand_pair();
    send_pair(p, 1'b0);
    wait_out();
    chk("bp_result", out_data, matmul(p[63:0], p[127:64]));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_data", out_data, matmul(p[63:0], p[127:64]));
    end
    p2 = rand_pair();
    for (int i = 0; i < 7; i++) send(p2[16*i +: 16]);
    chk("bp_overlap_valid", 64'(out_valid), 64'd1);
    chk("bp_overlap_data", out_data, matmul(p[63:0], p[127:64]));
    in_valid = 1'b1;
    in_data  = p2[127:112];
    #1 chk("stall_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_ready", 64'(in_ready), 64'd0);
      chk("stall_hold_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", 64'(in_ready), 64'd1);
    send(p2[127:112]);
    wait_out();
    chk("bp_next_result", out_data, matmul(p2[63:0], p2[127:64]));
    tick();

    // Input gaps
    send_pair({16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd0, 16'd0, 16'd2}, 1'b1);
    wait_out();
    chk("gaps_result", out_data, 64'h0002_0002_0002_0002);
    tick();

    // Reset mid-load
    p = rand_pair();
    for (int i = 0; i < 5; i++) send(p[16*i +: 16]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_mm_a", mm_a, 64'd0);
    chk("midrst_mm_b", mm_b, 64'd0);
    p = rand_pair();
    send_pair(p, 1'b0);
    wait_out();
    chk("midrst_result", out_data, matmul(p[63:0], p[127:64]));
    tick();

    // Back-to-back
    n0 = pop_cyc.size();
    for (int j = 0; j < 3; j++) send_pair(rand_pair(), 1'b0);
    n = 0;
    while (pop_cyc.size() < n0 + 3 && n < 40) begin
      tick();
      n++;
    end
    chk("b2b_count", 64'(pop_cyc.size() - n0), 64'd3);
    if (pop_cyc.size() >= n0 + 3) begin
      chk("b2b_spacing_1", 64'(pop_cyc[n0+1] - pop_cyc[n0]), 64'd9);
      chk("b2b_spacing_2", 64'(pop_cyc[n0+2] - pop_cyc[n0+1]), 64'd9);
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
